// File: rtl/switch_alloc_wh_pkg.sv
// Shared types, defaults and width helpers for the wormhole switch allocator.
// Optional feature macro: SA_GRANT_CNT_EN (per-output saturating grant counters).
package switch_alloc_pkg;

    typedef enum logic {OUT_IDLE = 1'b0, OUT_LOCKED = 1'b1} out_state_e;

    localparam int unsigned SA_N       = 5;
    localparam int unsigned SA_M       = 5;
    localparam int unsigned SA_CREDITS = 4;
    localparam int unsigned SA_CNT_W   = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned crd_w(input int unsigned c);
        return $clog2(c + 1);
    endfunction

    localparam int unsigned CRD_W = crd_w(SA_CREDITS);
    localparam int unsigned OWN_W = idx_w(SA_N);
    typedef logic [OWN_W-1:0] owner_t;

endpackage

// File: rtl/switch_alloc_wh_if.sv
// Request/grant/credit bundle between the input units, the allocator and the outputs.
// Optional feature macro: SA_GRANT_CNT_EN adds o_grant_cnt.
interface switch_alloc_wh_if #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 5
`ifdef SA_GRANT_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
    logic [N-1:0][M-1:0] i_output_req;
    logic [N-1:0]        i_tail;
    logic [M-1:0]        i_credit_return;
    logic [M-1:0][N-1:0] o_output_grant;
    logic [N-1:0]        o_input_grant;
    logic [M-1:0]        o_locked;
    logic [M-1:0]        o_credit_err;
`ifdef SA_GRANT_CNT_EN
    logic [M-1:0][CNT_W-1:0] o_grant_cnt;
`endif

    modport master (
`ifdef SA_GRANT_CNT_EN
        input  o_grant_cnt,
`endif
        output i_output_req, i_tail, i_credit_return,
        input  o_output_grant, o_input_grant, o_locked, o_credit_err
    );

    modport slave (
`ifdef SA_GRANT_CNT_EN
        output o_grant_cnt,
`endif
        input  i_output_req, i_tail, i_credit_return,
        output o_output_grant, o_input_grant, o_locked, o_credit_err
    );
endinterface

// File: rtl/switch_alloc_wh_sa_output_unit.sv
// One output port: round-robin head arbitration, wormhole lock FSM and credit counter.
// Optional feature macro: SA_GRANT_CNT_EN (saturating granted-flit counter).
module sa_output_unit
    import switch_alloc_pkg::*;
#(
    parameter int unsigned N       = SA_N,
    parameter int unsigned CREDITS = SA_CREDITS
`ifdef SA_GRANT_CNT_EN
  , parameter int unsigned CNT_W   = SA_CNT_W
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_tail,
    input  logic         i_credit_return,
    output logic [N-1:0] o_grant,
    output logic         o_locked,
    output logic         o_credit_err
`ifdef SA_GRANT_CNT_EN
  , output logic [CNT_W-1:0] o_grant_cnt
`endif
);
    localparam int unsigned IDX_W = idx_w(N);
    localparam int unsigned CW    = crd_w(CREDITS);
    localparam logic [CW-1:0] CRD_MAX = CW'(CREDITS);
    typedef logic [IDX_W-1:0] idx_t;

    out_state_e    r_state;
    idx_t          r_ptr;
    idx_t          r_owner;
    logic [CW-1:0] r_credit;
    logic          r_credit_err;

    logic          w_elig;
    logic          w_found;
    idx_t          w_gidx;
    idx_t          w_ptr_nxt;
    logic [N-1:0]  w_grant;

    assign w_elig = ce && (r_credit != '0);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        if (w_elig) begin
            if (r_state == OUT_LOCKED) begin
                w_found = i_req[r_owner];
                w_gidx  = r_owner;
            end else begin
                for (int unsigned off = N; off > 0; off--) begin
                    cand = (32'(r_ptr) + off - 1) % N;
                    if (i_req[idx_t'(cand)]) begin
                        w_found = 1'b1;
                        w_gidx  = idx_t'(cand);
                    end
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) w_grant[w_gidx] = 1'b1;
    end

    assign w_ptr_nxt = (w_gidx == idx_t'(N - 1)) ? '0 : idx_t'(w_gidx + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= OUT_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_credit     <= CRD_MAX;
            r_credit_err <= 1'b0;
        end else begin
            if (w_found) begin
                if (r_state == OUT_IDLE) begin
                    r_ptr <= w_ptr_nxt;
                    if (!i_tail[w_gidx]) begin
                        r_state <= OUT_LOCKED;
                        r_owner <= w_gidx;
                    end
                end else if (i_tail[w_gidx]) begin
                    r_state <= OUT_IDLE;
                end
            end
            // Returns are honoured even while ce is low; grants never are.
            case ({w_found, i_credit_return})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01: begin
                    if (r_credit == CRD_MAX) r_credit_err <= 1'b1;
                    else                     r_credit     <= r_credit + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_grant      = w_grant;
    assign o_locked     = (r_state == OUT_LOCKED);
    assign o_credit_err = r_credit_err;

`ifdef SA_GRANT_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           r_grant_cnt <= '0;
        else if (w_found && r_grant_cnt != '1)  r_grant_cnt <= r_grant_cnt + 1'b1;
    end

    assign o_grant_cnt = r_grant_cnt;
`endif
endmodule

// File: rtl/switch_alloc_wh.sv
// Wormhole switch allocator top: request sanitise/transpose, per-output units, input-grant OR.
// Optional feature macro: SA_GRANT_CNT_EN (per-output grant counters on o_grant_cnt).
module switch_alloc_wh
    import switch_alloc_pkg::*;
#(
    parameter int unsigned N       = SA_N,
    parameter int unsigned M       = SA_M,
    parameter int unsigned CREDITS = SA_CREDITS
`ifdef SA_GRANT_CNT_EN
  , parameter int unsigned CNT_W   = SA_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    switch_alloc_wh_if.slave  bus
);
    logic [N-1:0][M-1:0] w_req_san;
    logic [M-1:0][N-1:0] w_req_t;
    logic [M-1:0][N-1:0] w_out_grant;
    logic [N-1:0]        w_input_grant;
    logic [M-1:0]        w_locked;
    logic [M-1:0]        w_credit_err;
`ifdef SA_GRANT_CNT_EN
    logic [M-1:0][CNT_W-1:0] w_grant_cnt;
`endif

    // x & -x keeps only the lowest set request bit of each input.
    always_comb begin
        w_req_san = '0;
        w_req_t   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_req_san[j] = bus.i_output_req[j] & (~bus.i_output_req[j] + M'(1));
        end
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                w_req_t[i][j] = w_req_san[j][i];
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_out
        sa_output_unit #(
            .N       (N),
            .CREDITS (CREDITS)
`ifdef SA_GRANT_CNT_EN
          , .CNT_W   (CNT_W)
`endif
        ) u_out (
            .clk             (clk),
            .reset_n         (reset_n),
            .ce              (ce),
            .i_req           (w_req_t[i]),
            .i_tail          (bus.i_tail),
            .i_credit_return (bus.i_credit_return[i]),
            .o_grant         (w_out_grant[i]),
            .o_locked        (w_locked[i]),
            .o_credit_err    (w_credit_err[i])
`ifdef SA_GRANT_CNT_EN
          , .o_grant_cnt     (w_grant_cnt[i])
`endif
        );
    end

    always_comb begin
        w_input_grant = '0;
        for (int unsigned i = 0; i < M; i++) begin
            w_input_grant = w_input_grant | w_out_grant[i];
        end
    end

    assign bus.o_output_grant = w_out_grant;
    assign bus.o_input_grant  = w_input_grant;
    assign bus.o_locked       = w_locked;
    assign bus.o_credit_err   = w_credit_err;
`ifdef SA_GRANT_CNT_EN
    assign bus.o_grant_cnt    = w_grant_cnt;
`endif
endmodule

// File: tb/tb_switch_alloc_wh.sv
// Directed scoreboard bench for switch_alloc_wh (N=M=5, CREDITS=4).
// Counter checks are compiled in only when SA_GRANT_CNT_EN is defined.
`timescale 1ns/1ps
module tb_switch_alloc_wh;
    import switch_alloc_pkg::*;

    localparam int unsigned N = 5;
    localparam int unsigned M = 5;

    typedef logic [N-1:0][M-1:0] rvec_t;
    typedef logic [M-1:0][N-1:0] gvec_t;
    typedef struct {
        string        tag;
        gvec_t        g;
        logic [M-1:0] lk;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;
    always #5 clk = ~clk;

    switch_alloc_wh_if #(.N(N), .M(M)) bus ();

    switch_alloc_wh #(.N(N), .M(M), .CREDITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic rvec_t rq(input int i, input int o);
        rvec_t r = '0;
        r[i][o] = 1'b1;
        return r;
    endfunction

    function automatic gvec_t gr(input int o, input int i);
        gvec_t g = '0;
        g[o][i] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        logic [N-1:0] ig;
        @(negedge clk);
        e  = sb.pop_front();
        ig = '0;
        for (int i = 0; i < M; i++) ig = ig | e.g[i];
        chk({e.tag, " output_grant"}, 64'(bus.o_output_grant), 64'(e.g));
        chk({e.tag, " input_grant"},  64'(bus.o_input_grant),  64'(ig));
        chk({e.tag, " locked"},       64'(bus.o_locked),       64'(e.lk));
    endtask

    task automatic step(input string tag, input rvec_t req, input logic [N-1:0] tail,
                        input logic [M-1:0] cr, input gvec_t g, input logic [M-1:0] lk,
                        input logic ce_v = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i_output_req    = req;
        bus.i_tail          = tail;
        bus.i_credit_return = cr;
        ce                  = ce_v;
        e.tag = tag; e.g = g; e.lk = lk;
        sb.push_back(e);
        check_out();
    endtask

    initial begin
        int    seq [6];
        rvec_t r;
        exp_t  e;

        bus.i_output_req    = '0;
        bus.i_tail          = '0;
        bus.i_credit_return = '0;

        // Reset state
        repeat (2) @(negedge clk);
        e.tag = "reset"; e.g = '0; e.lk = '0;
        sb.push_back(e);
        check_out();
        chk("reset credit_err", 64'(bus.o_credit_err), 64'(0));
        #2 reset_n = 1'b1;
        step("idle", '0, '0, '0, '0, '0);

        // Round robin on output 1 among inputs 0,2,3, single-flit packets, credits returned
        seq = '{0, 2, 3, 0, 2, 3};
        r   = rq(0, 1) | rq(2, 1) | rq(3, 1);
        for (int k = 0; k < 6; k++) step("rr", r, '1, 5'b00010, gr(1, seq[k]), '0);
        step("rr_end", '0, '0, '0, '0, '0);
        chk("rr credit_err", 64'(bus.o_credit_err), 64'(0));
`ifdef SA_GRANT_CNT_EN
        chk("rr grant_cnt1", 64'(bus.o_grant_cnt[1]), 64'(6));
`endif

        // Multi-bit request: only lowest output honoured
        r = '0; r[3][3] = 1'b1; r[3][4] = 1'b1;
        step("sanitise", r, '1, '0, gr(3, 3), '0);

        // Clock enable low forces grants off and holds state
        step("ce_off", rq(0, 4), '1, '0, '0, '0, 1'b0);
        step("ce_on",  rq(0, 4), '1, '0, gr(4, 0), '0);

        // 3-flit packet with a bubble from input 1 to output 0, input 4 competing
        r = rq(1, 0) | rq(4, 0);
        step("wh_head",   r,         5'b00000, '0, gr(0, 1), 5'b00000);
        step("wh_body",   r,         5'b00000, '0, gr(0, 1), 5'b00001);
        step("wh_bubble", rq(4, 0),  5'b10000, '0, '0,       5'b00001);
        step("wh_tail",   r,         5'b10010, '0, gr(0, 1), 5'b00001);
        step("wh_next",   rq(4, 0),  5'b10000, '0, gr(0, 4), 5'b00000);
        step("wh_nocrd",  rq(4, 0),  5'b10000, '0, '0,       5'b00000);
        for (int k = 0; k < 4; k++) step("wh_ret", '0, '0, 5'b00001, '0, '0);
        chk("wh credit_err", 64'(bus.o_credit_err), 64'(0));

        // Credit exhaustion on output 2
        for (int k = 0; k < 4; k++) step("crd_burst", rq(0, 2), '1, '0, gr(2, 0), '0);
        step("crd_stall0", rq(0, 2), '1, '0,       '0,       '0);
        step("crd_stall1", rq(0, 2), '1, '0,       '0,       '0);
        step("crd_nobyp",  rq(0, 2), '1, 5'b00100, '0,       '0);
        step("crd_one",    rq(0, 2), '1, '0,       gr(2, 0), '0);
        step("crd_stall2", rq(0, 2), '1, '0,       '0,       '0);

        // Simultaneous grant and return at credit 1, then overflow
        step("sim_ret",   '0,        '0, 5'b00100, '0,       '0);
        step("sim_both",  rq(0, 2), '1, 5'b00100, gr(2, 0), '0);
        step("sim_last",  rq(0, 2), '1, '0,       gr(2, 0), '0);
        step("sim_empty", rq(0, 2), '1, '0,       '0,       '0);
        for (int k = 0; k < 4; k++) step("sim_refill", '0, '0, 5'b00100, '0, '0);
        step("sim_full", '0, '0, '0, '0, '0);
        chk("full credit_err", 64'(bus.o_credit_err), 64'(0));
        step("ovf_ret", '0, '0, 5'b00100, '0, '0);
        step("ovf_idle", '0, '0, '0, '0, '0);
        chk("ovf credit_err", 64'(bus.o_credit_err), 64'(5'b00100));
        step("ovf_grant", rq(0, 2), '1, '0, gr(2, 0), '0);
        step("ovf_hold", '0, '0, '0, '0, '0);
        chk("sticky credit_err", 64'(bus.o_credit_err), 64'(5'b00100));

        // Reset mid-packet on output 3 (pointer at 4, credit 3 before the head)
        step("rst_head", rq(2, 3), 5'b00000, '0, gr(3, 2), 5'b00000);
        step("rst_lock", '0,       5'b00000, '0, '0,       5'b01000);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst locked",     64'(bus.o_locked),       64'(0));
        chk("rst credit_err", 64'(bus.o_credit_err),   64'(0));
        chk("rst grant",      64'(bus.o_output_grant), 64'(0));
`ifdef SA_GRANT_CNT_EN
        for (int i = 0; i < M; i++) chk("rst grant_cnt", 64'(bus.o_grant_cnt[i]), 64'(0));
`endif
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step("post_rst", rq(2, 3), '1, '0, gr(3, 2), '0);
        step("post_rst_stall", rq(2, 3), '1, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL timeout act=running exp=finished");
    end
endmodule
